// File: rtl/display_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Package : display_pkg
// Brief   : Default sizing constants and index-width helper for the scanner.
// Rev     : 1.0
// ============================================================================
package display_pkg;

  localparam int c_NUM_DIGITS   = 4;
  localparam int c_DIGIT_W      = 4;
  localparam int c_REFRESH_DIV  = 100000;
  localparam int c_BLANK_CYCLES = 1000;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Interface : display_scan_mux_if
// Brief     : Value source / display side signals of the digit scanner.
// Rev       : 1.0
// ============================================================================
interface display_scan_mux_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = c_NUM_DIGITS,
  parameter int DIGIT_W    = c_DIGIT_W
);

  localparam int c_IDX_W = idx_width(NUM_DIGITS);

  logic                          enable;
  logic [NUM_DIGITS*DIGIT_W-1:0] value_i;
  logic [c_IDX_W-1:0]            digit_idx;
  logic [NUM_DIGITS-1:0]         anode_n;
  logic [DIGIT_W-1:0]            selected_digit;
  logic                          blank;
  logic                          frame_start;

  modport master (
    output enable, value_i,
    input  digit_idx, anode_n, selected_digit, blank, frame_start
  );

  modport slave (
    input  enable, value_i,
    output digit_idx, anode_n, selected_digit, blank, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/display_scan_mux_scan_tick_counter.sv
`default_nettype none
// ============================================================================
// Module : scan_tick_counter
// Brief  : Modulo-REFRESH_DIV slot counter with a terminal-count strobe.
// Rev    : 1.0
// ============================================================================
module scan_tick_counter
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = c_REFRESH_DIV,
  parameter int CNT_W       = idx_width(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign cnt = r_cnt;
  assign tc  = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module : display_scan_mux
// Brief  : Self-running N-digit seven-segment scanner with per-frame snapshot,
//          anti-ghost blank interval and optional leading-zero blanking
//          (enabled by defining DISPLAY_LZ_BLANK_EN).
// Rev    : 1.0
// ============================================================================
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = c_NUM_DIGITS,
  parameter int DIGIT_W      = c_DIGIT_W,
  parameter int REFRESH_DIV  = c_REFRESH_DIV,
  parameter int BLANK_CYCLES = c_BLANK_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_mux_if.slave   bus
);

  localparam int c_IDX_W = idx_width(NUM_DIGITS);
  localparam int c_CNT_W = idx_width(REFRESH_DIV);
  localparam int c_VAL_W = NUM_DIGITS * DIGIT_W;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_DIGITS - 1);

  logic [c_CNT_W-1:0]    w_cnt;
  logic                  w_tc;
  logic [c_CNT_W-1:0]    w_cnt_next;
  logic [c_IDX_W-1:0]    w_idx_next;
  logic                  w_frame_wrap;
  logic [c_VAL_W-1:0]    w_snap_next;
  logic [DIGIT_W-1:0]    w_sel_next;
  logic                  w_blank_next;
  logic                  w_window;
  logic [NUM_DIGITS-1:0] w_anode_next;

  logic [c_IDX_W-1:0]    r_idx;
  logic [c_VAL_W-1:0]    r_snap;
  logic [NUM_DIGITS-1:0] r_anode_n;
  logic [DIGIT_W-1:0]    r_sel;
  logic                  r_blank;
  logic                  r_frame_start;

  scan_tick_counter #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (c_CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (w_cnt),
    .tc    (w_tc)
  );

  // Outputs are registered from next-state values so they line up with digit_idx.
  assign w_cnt_next   = w_tc ? '0 : (w_cnt + c_CNT_W'(1));
  assign w_frame_wrap = w_tc && (r_idx == c_LAST_IDX);
  assign w_idx_next   = !w_tc ? r_idx :
                        (r_idx == c_LAST_IDX) ? '0 : (r_idx + c_IDX_W'(1));
  assign w_snap_next  = w_frame_wrap ? bus.value_i : r_snap;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank_window
      assign w_window = 1'b1;
    end else begin : g_blank_window
      assign w_window = (w_cnt_next >= c_CNT_W'(BLANK_CYCLES));
    end
  endgenerate

`ifdef DISPLAY_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] r_mask;
  logic [NUM_DIGITS-1:0] w_mask_cap;
  logic [NUM_DIGITS-1:0] w_mask_next;
  logic                  w_zero_run;

  // Digit i is blanked when it and every more significant digit are zero.
  always_comb begin
    w_mask_cap = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_run    = w_zero_run & (bus.value_i[i*DIGIT_W +: DIGIT_W] == '0);
      w_mask_cap[i] = w_zero_run;
    end
  end

  assign w_mask_next = w_frame_wrap ? w_mask_cap : r_mask;

  always_comb begin
    w_blank_next = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == c_IDX_W'(i)) w_blank_next = w_mask_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mask <= '0;
    else        r_mask <= w_mask_next;
  end
`else
  assign w_blank_next = 1'b0;
`endif

  always_comb begin
    w_sel_next   = '0;
    w_anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == c_IDX_W'(i)) begin
        w_sel_next      = w_snap_next[i*DIGIT_W +: DIGIT_W];
        w_anode_next[i] = !(w_window && bus.enable && !w_blank_next);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_snap        <= '0;
      r_anode_n     <= '1;
      r_sel         <= '0;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_idx         <= w_idx_next;
      r_snap        <= w_snap_next;
      r_anode_n     <= w_anode_next;
      r_sel         <= w_sel_next;
      r_blank       <= w_blank_next;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign bus.digit_idx      = r_idx;
  assign bus.anode_n        = r_anode_n;
  assign bus.selected_digit = r_sel;
  assign bus.blank          = r_blank;
  assign bus.frame_start    = r_frame_start;

endmodule
`default_nettype wire
